// File: rtl/spi_ram_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_ram_arbiter
//   Decodes SPI slave command words into accesses on one single-port
//   synchronous RAM and shares that RAM with a local host port using
//   round-robin arbitration.
//
//   Command word: [ADDR_SIZE+1:ADDR_SIZE] opcode, [ADDR_SIZE-1:0] payload
//     00 wr_addr <- payload      01 RAM[wr_addr] <- payload
//     10 rd_addr <- payload      11 read RAM[rd_addr] -> tx_data/tx_valid
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     rx_data, rx_valid        command word from SPI slave (1-cycle strobe)
//     tx_data, tx_valid        read data back to SPI slave (1-cycle strobe)
//     host_req/we/addr/wdata   host request (level, held until host_gnt)
//     host_gnt                 host access issued to RAM this cycle
//     host_rdata, host_rvalid  host read data (two cycles after host_gnt)
//     ram_en/we/addr/wdata     registered RAM controls
//     ram_rdata                RAM read data, valid one cycle after a read
//     ovf_clr, overflow        sticky dropped-command flag and its clear
//
//   Build option: define SPI_AUTO_INC_EN to post-increment wr_addr after each
//   SPI write and rd_addr after each SPI read issue.
// -----------------------------------------------------------------------------
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE+1:0] rx_data,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [ADDR_SIZE-1:0] host_wdata,
  output logic                 host_gnt,
  output logic [ADDR_SIZE-1:0] host_rdata,
  output logic                 host_rvalid,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [ADDR_SIZE-1:0] ram_wdata,
  input  logic [ADDR_SIZE-1:0] ram_rdata,
  input  logic                 ovf_clr,
  output logic                 overflow
);

  typedef enum logic {ARB, RD_WAIT} state_t;

  localparam logic OWNER_HOST = 1'b0;
  localparam logic OWNER_SPI  = 1'b1;
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = 1;

  state_t                 state_reg;
  logic                   pend_valid_reg;
  logic [ADDR_SIZE+1:0]   pend_data_reg;
  logic [ADDR_SIZE-1:0]   wr_addr_reg;
  logic [ADDR_SIZE-1:0]   rd_addr_reg;
  logic                   last_winner_reg;
  logic                   rd_owner_reg;
  logic                   capture_reg;   // ram_rdata is valid this cycle

  logic [1:0]             pend_op;
  logic [ADDR_SIZE-1:0]   pend_payload;
  logic                   spi_ram_req;
  logic                   host_ram_req;
  logic                   grant_spi;
  logic                   grant_host;
  logic                   retire;
  logic                   rx_accept;
  logic                   rx_drop;

  always_comb begin
    pend_op      = pend_data_reg[ADDR_SIZE+1:ADDR_SIZE];
    pend_payload = pend_data_reg[ADDR_SIZE-1:0];
    spi_ram_req  = (state_reg == ARB) && pend_valid_reg && pend_op[0];
    // host_gnt is registered, so while it is high the host is still showing
    // the request that was just served; it must not be granted twice.
    host_ram_req = (state_reg == ARB) && host_req && !host_gnt;
    grant_spi    = spi_ram_req && (!host_ram_req || (last_winner_reg == OWNER_HOST));
    grant_host   = host_ram_req && !grant_spi;
    // Address loads retire unconditionally; RAM commands only when granted.
    retire       = (state_reg == ARB) && pend_valid_reg && (!pend_op[0] || grant_spi);
    rx_accept    = rx_valid && (!pend_valid_reg || retire);
    rx_drop      = rx_valid && !rx_accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ARB;
      pend_valid_reg  <= 1'b0;
      pend_data_reg   <= '0;
      wr_addr_reg     <= '0;
      rd_addr_reg     <= '0;
      last_winner_reg <= OWNER_HOST;
      rd_owner_reg    <= OWNER_HOST;
      capture_reg     <= 1'b0;
      tx_data         <= '0;
      tx_valid        <= 1'b0;
      host_gnt        <= 1'b0;
      host_rdata      <= '0;
      host_rvalid     <= 1'b0;
      ram_en          <= 1'b0;
      ram_we          <= 1'b0;
      ram_addr        <= '0;
      ram_wdata       <= '0;
      overflow        <= 1'b0;
    end else begin
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      host_gnt    <= 1'b0;
      tx_valid    <= 1'b0;
      host_rvalid <= 1'b0;
      capture_reg <= 1'b0;

      // rd_owner_reg cannot change before this cycle's edge, so it still
      // names the owner of the read whose data is on ram_rdata now.
      if (capture_reg) begin
        if (rd_owner_reg == OWNER_SPI) begin
          tx_data  <= ram_rdata;
          tx_valid <= 1'b1;
        end else begin
          host_rdata  <= ram_rdata;
          host_rvalid <= 1'b1;
        end
      end

      if (rx_accept) begin
        pend_valid_reg <= 1'b1;
        pend_data_reg  <= rx_data;
      end else if (retire) begin
        pend_valid_reg <= 1'b0;
      end

      if (rx_drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

      case (state_reg)
        ARB: begin
          if (pend_valid_reg && !pend_op[0]) begin
            if (pend_op[1]) rd_addr_reg <= pend_payload;
            else            wr_addr_reg <= pend_payload;
          end
          if (grant_spi) begin
            ram_en          <= 1'b1;
            last_winner_reg <= OWNER_SPI;
            if (pend_op[1]) begin
              ram_we       <= 1'b0;
              ram_addr     <= rd_addr_reg;
              rd_owner_reg <= OWNER_SPI;
              state_reg    <= RD_WAIT;
`ifdef SPI_AUTO_INC_EN
              rd_addr_reg  <= rd_addr_reg + ADDR_ONE;
`endif
            end else begin
              ram_we      <= 1'b1;
              ram_addr    <= wr_addr_reg;
              ram_wdata   <= pend_payload;
`ifdef SPI_AUTO_INC_EN
              wr_addr_reg <= wr_addr_reg + ADDR_ONE;
`endif
            end
          end else if (grant_host) begin
            ram_en          <= 1'b1;
            ram_we          <= host_we;
            ram_addr        <= host_addr;
            host_gnt        <= 1'b1;
            last_winner_reg <= OWNER_HOST;
            if (host_we) begin
              ram_wdata <= host_wdata;
            end else begin
              rd_owner_reg <= OWNER_HOST;
              state_reg    <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          capture_reg <= 1'b1;
          state_reg   <= ARB;
        end
        default: state_reg <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_ram_arbiter
//   Self-checking bench: directed scenarios for the documented corner cases,
//   then a randomized phase where SPI and host traffic run concurrently on
//   disjoint address halves, checked against a transaction-level memory model.
//   Honours SPI_AUTO_INC_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata;
  logic       ovf_clr;
  logic       overflow;
  logic       ram_reload;

  spi_ram_arbiter #(.ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ovf_clr(ovf_clr), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] initval(input int a);
    logic [7:0] v;
    v = a[7:0];
    return v ^ 8'hA5;
  endfunction

  // Behavioural single-port synchronous RAM.
  logic [7:0] ram_mem [0:255];
  always @(posedge clk) begin
    if (ram_reload) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= initval(i);
    end else if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Bus monitors.
  logic [15:0] wr_log [$];
  int          tx_cnt = 0;
  int          rv_cnt = 0;
  logic        mon_en = 1'b0;
  logic [7:0]  exp_tx [$];
  logic [7:0]  ref_mem [0:255];

  always @(negedge clk) begin
    if (ram_en && ram_we) wr_log.push_back({ram_addr, ram_wdata});
    if (tx_valid) tx_cnt++;
    if (host_rvalid) rv_cnt++;
    if (mon_en && tx_valid) begin
      if (exp_tx.size() == 0) chk("rnd_tx_unexpected", 32'd1, 32'd0);
      else chk("rnd_tx", tx_data, exp_tx.pop_front());
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ram_reload = 1'b1;
    rx_valid = 1'b0; host_req = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; ram_reload = 1'b0;
  endtask

  task automatic check_outs_zero(input string tag);
    chk({tag, "_data"}, {tx_data, host_rdata, ram_addr, ram_wdata}, 32'h0);
    chk({tag, "_ctl"}, {tx_valid, host_gnt, host_rvalid, ram_en, ram_we, overflow}, 32'h0);
  endtask

  task automatic spi_send(input logic [9:0] cmd);
    @(negedge clk);
    rx_data = cmd; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Three back-to-back commands: a read, then a write that waits out RD_WAIT,
  // then a write that finds the buffer full and must be dropped.
  task automatic ovf_burst(input logic [7:0] keep, input logic [7:0] lose, input logic clr_on_drop);
    @(negedge clk); rx_data = 10'h300;          rx_valid = 1'b1;
    @(negedge clk); rx_data = {2'b01, keep};
    @(negedge clk); rx_data = {2'b01, lose};    ovf_clr = clr_on_drop;
    @(negedge clk); rx_valid = 1'b0;            ovf_clr = 1'b0;
  endtask

  task automatic spi_rand();
    logic [7:0] m_wr = 8'h00;
    logic [7:0] m_rd = 8'h00;
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [7:0] p;
      op = $urandom_range(0, 3);
      if (op == 1 && m_wr >= 8'h70) op = 0;
      if (op == 3 && m_rd >= 8'h70) op = 2;
      p = (op == 0 || op == 2) ? 8'($urandom_range(0, 8'h6F)) : 8'($urandom_range(0, 255));
      case (op)
        0: m_wr = p;
        1: begin
          ref_mem[m_wr] = p;
`ifdef SPI_AUTO_INC_EN
          m_wr = m_wr + 8'd1;
`endif
        end
        2: m_rd = p;
        default: begin
          exp_tx.push_back(ref_mem[m_rd]);
`ifdef SPI_AUTO_INC_EN
          m_rd = m_rd + 8'd1;
`endif
        end
      endcase
      spi_send({2'(op), p});
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic host_rand();
    for (int j = 0; j < 30; j++) begin
      int waited;
      logic [7:0] a, d;
      logic we;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      a = 8'($urandom_range(128, 255));
      d = 8'($urandom_range(0, 255));
      we = 1'($urandom_range(0, 1));
      host_addr = a; host_we = we; host_wdata = d; host_req = 1'b1;
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!host_gnt && waited < 40);
      chk("rnd_host_gnt", host_gnt, 1'b1);
      host_req = 1'b0;
      if (we) begin
        ref_mem[a] = d;
      end else begin
        repeat (2) @(negedge clk);
        chk("rnd_host_rvalid", host_rvalid, 1'b1);
        chk("rnd_host_rdata", host_rdata, ref_mem[a]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, n, cnt, hg, found;
    logic [15:0] w0, w1;
    rx_data = '0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    // Reset values.
    do_reset();
    check_outs_zero("reset");

    // SPI write: 0x2A <- 0x5C.
    spi_send(10'h02A);
    spi_send(10'h15C);
    @(negedge clk);
    chk("spi_wr_ctl", {ram_en, ram_we}, 2'b11);
    chk("spi_wr_addr", ram_addr, 8'h2A);
    chk("spi_wr_data", ram_wdata, 8'h5C);
    @(negedge clk);
    chk("spi_wr_once", ram_en, 1'b0);

    // SPI read back from 0x2A.
    spi_send(10'h22A);
    spi_send(10'h300);
    @(negedge clk);
    chk("spi_rd_issue", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 8'h2A});
    @(negedge clk);
    chk("spi_txv_early", tx_valid, 1'b0);
    @(negedge clk);
    chk("spi_txv", tx_valid, 1'b1);
    chk("spi_txd", tx_data, 8'h5C);
    @(negedge clk);
    chk("spi_txv_once", tx_valid, 1'b0);
    chk("spi_txd_hold", tx_data, 8'h5C);

    // Contention right after reset: SPI wins first.
    do_reset();
    spi_send(10'h001);
    spi_send(10'h177);
    host_we = 1'b0; host_addr = 8'h10; host_req = 1'b1;
    @(negedge clk);
    chk("ct_spi_first", {ram_en, ram_we, host_gnt}, 3'b110);
    chk("ct_spi_aw", {ram_addr, ram_wdata}, 16'h0177);
    @(negedge clk);
    chk("ct_host_gnt", {host_gnt, ram_en, ram_we}, 3'b110);
    chk("ct_host_addr", ram_addr, 8'h10);
    host_req = 1'b0;
    @(negedge clk);
    chk("ct_rv_early", host_rvalid, 1'b0);
    @(negedge clk);
    chk("ct_rv", host_rvalid, 1'b1);
    chk("ct_rdata", host_rdata, initval(8'h10));

    // Host holds read requests while SPI writes keep arriving.
    host_we = 1'b0; host_addr = 8'h20; host_req = 1'b1;
    hg = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      rx_data = {2'b01, 8'(8'hC0 + k)}; rx_valid = 1'b1;
      cnt = 0; found = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
        @(negedge clk);
        rx_valid = 1'b0;
        if (host_gnt) hg++;
        if (ram_en) begin
          cnt++;
          if (ram_we && ram_wdata == 8'(8'hC0 + k)) found = 1;
        end
      end
      chk("hold_spi_served", found, 1);
      chk("hold_spi_slots_le2", (cnt <= 2), 1'b1);
    end
    host_req = 1'b0;
    chk("hold_host_served", (hg >= 3), 1'b1);
    repeat (4) @(negedge clk);
    chk("hold_no_ovf", overflow, 1'b0);

    // Overflow: second write during RD_WAIT is dropped.
    spi_send(10'h040);
    base = wr_log.size();
    ovf_burst(8'hAA, 8'hBB, 1'b0);
    chk("ovf_set", overflow, 1'b1);
    repeat (6) @(negedge clk);
    n = wr_log.size() - base;
    w0 = (n > 0) ? wr_log[base] : 16'h0;
    chk("ovf_wr_count", n, 1);
    chk("ovf_wr_first", w0, 16'h40AA);
    chk("ovf_sticky", overflow, 1'b1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);
    ovf_burst(8'hCC, 8'hDD, 1'b1);
    chk("ovf_drop_beats_clr", overflow, 1'b1);
    repeat (4) @(negedge clk);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;

    // Reset during RD_WAIT discards the in-flight read.
    spi_send(10'h300);
    @(negedge clk);
    chk("rstmid_rd_issue", {ram_en, ram_we}, 2'b10);
    base = tx_cnt + rv_cnt;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_outs_zero("rstmid");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstmid_no_rdata", tx_cnt + rv_cnt - base, 0);

    // Address wrap / auto-increment.
    base = wr_log.size();
    spi_send(10'h0FF);
    spi_send(10'h111);
    spi_send(10'h122);
    repeat (4) @(negedge clk);
    n = wr_log.size() - base;
    w0 = (n > 0) ? wr_log[base] : 16'h0;
    w1 = (n > 1) ? wr_log[base + 1] : 16'h0;
    chk("inc_wr_count", n, 2);
    chk("inc_wr_first", w0, 16'hFF11);
`ifdef SPI_AUTO_INC_EN
    chk("inc_wr_second", w1, 16'h0022);
`else
    chk("inc_wr_second", w1, 16'hFF22);
`endif

    // Randomized concurrent traffic.
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = initval(i);
    mon_en = 1'b1;
    fork
      spi_rand();
      host_rand();
    join
    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    chk("rnd_tx_all_seen", exp_tx.size(), 0);
    chk("rnd_no_ovf", overflow, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Sequencing and arbitration controller between the SPI slave, a local host port and one single-port synchronous RAM. Decodes the SPI slave's 10-bit command words into RAM accesses using internal write/read address registers. Returns read data to the SPI slave for serialisation on MISO. Shares the RAM with the host port using round-robin arbitration.

## Interface
- ADDR_SIZE, 8: RAM address width and data width; SPI command word is ADDR_SIZE+2 bits.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  ADDR_SIZE+2  SPI command: [ADDR_SIZE+1:ADDR_SIZE] opcode, [ADDR_SIZE-1:0] payload.
- rx_valid  in  1  single-cycle strobe, rx_data valid.
- tx_data  out  ADDR_SIZE  read data to SPI slave.
- tx_valid  out  1  single-cycle strobe, tx_data valid.
- host_req  in  1  host access request, level, held until host_gnt.
- host_we  in  1  1 = write, 0 = read; stable while host_req.
- host_addr  in  ADDR_SIZE  host address.
- host_wdata  in  ADDR_SIZE  host write data.
- host_gnt  out  1  one-cycle pulse, host access issued to RAM this cycle.
- host_rdata  out  ADDR_SIZE  host read data.
- host_rvalid  out  1  one-cycle pulse, host_rdata valid.
- ram_en, ram_we  out  1  RAM enable / write enable.
- ram_addr, ram_wdata  out  ADDR_SIZE  RAM address / write data.
- ram_rdata  in  ADDR_SIZE  RAM read data, valid one cycle after a read.
- ovf_clr  in  1  clears overflow.
- overflow  out  1  sticky: an SPI command was dropped.

## Operation
- SPI opcodes: 00 load wr_addr ← payload; 01 write payload to RAM[wr_addr]; 10 load rd_addr ← payload; 11 read RAM[rd_addr], payload ignored.
- One-entry SPI pending buffer, loaded on rx_valid.
- States: ARB, RD_WAIT.
- ARB, pending opcode 00/10: address register updated, entry retired. No RAM slot used. Host may be granted the same cycle.
- ARB, RAM requesters: pending 01/11 (SPI) and host_req (host).
  - Only one requesting: it wins.
  - Both requesting: winner is the one not granted last. last_winner resets to host, so SPI wins the first contention.
- Winning write: ram_en=1, ram_we=1 for that cycle. Stay ARB.
- Winning read: ram_en=1, ram_we=0. Go to RD_WAIT.
- Host win: host_gnt pulses. SPI win: pending entry retired.
- RD_WAIT lasts one cycle, no grants issued.
  - Capture ram_rdata into tx_data (pulse tx_valid) or host_rdata (pulse host_rvalid), per the read's owner.
  - Return to ARB.
- ram_en=0 whenever no access is issued; ram_addr/ram_wdata hold last value.
- Overflow:
  - rx_valid while pending is full and not retiring this cycle: new command dropped, overflow←1.
  - rx_valid in the same cycle the entry retires: new command accepted.
  - overflow cleared only by rst or ovf_clr; rx drop wins over ovf_clr in the same cycle.
- Reset mid-operation: state←ARB, pending emptied, in-flight read discarded (no tx_valid/host_rvalid afterwards).

## Timing
- Reset values:
  - All outputs 0: tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, ram_en, ram_we, ram_addr, ram_wdata, overflow.
  - wr_addr=rd_addr=0, last_winner=host, state ARB.
- rx_valid at cycle t → pending at t+1 → earliest RAM access at t+1 (registered outputs at t+2 edge).
- All RAM outputs registered. Read issued cycle n → ram_rdata sampled n+1 → tx_valid/host_rvalid high cycle n+2.
- Host write latency: grant cycle = write cycle. Host read: host_rvalid two cycles after host_gnt.
- tx_data/host_rdata hold until the next read of that owner.
- Address registers are ADDR_SIZE bits and wrap modulo 2^ADDR_SIZE.

## Configuration
- SPI_AUTO_INC_EN defined:
  - After each SPI opcode-01 write, wr_addr←wr_addr+1.
  - After each SPI opcode-11 read issue, rd_addr←rd_addr+1.
  - Both wrap 0xFF→0x00.
- Not defined: address registers change only on opcodes 00/10.
- Host path is identical in both builds.

## Test plan
- SPI write: rx 0x02A (00), then rx 0x15C (01) → one cycle ram_en=1, ram_we=1, ram_addr=0x2A, ram_wdata=0x5C.
- SPI read: after the write, rx 0x22A (10), then rx 0x300 (11) → ram read addr 0x2A; two cycles later tx_data=0x5C, tx_valid high for exactly one cycle.
- Contention after reset: pending 01 write 0x77 to wr_addr 0x01, plus host_req read of 0x10 in the same cycle → SPI write first, host_gnt next cycle, host_rvalid with RAM[0x10] two cycles after that.
- Host hold: host_req held with reads while SPI 01 commands arrive → grants alternate SPI/host; no SPI command waits more than 2 RAM slots.
- Overflow: pending 01 blocked during RD_WAIT, rx_valid again → second command dropped, overflow=1 until ovf_clr pulse, only first write reaches RAM; then rst asserted during RD_WAIT → no tx_valid/host_rvalid, all outputs 0.
- SPI_AUTO_INC_EN: rx 0x0FF, then 0x111, then 0x122 → writes to 0xFF then 0x00; without the macro both writes go to 0xFF.
